pwm_ramp_sequencer: RTL and testbench

AXI4-Lite master that configures and sequences the My_PWM_core register file without processor involvement. On `start` it programs the PWM period and enables the core. It then steps the duty-cycle register from a start value to an end value, one step every `C_TICK_DIV` clock cycles, to produce a hardware fade/ramp. It sits between local control logic and the PWM core's `S00_AXI` slave port, or an interconnect slot in front of it.

---
 rtl/pwm_ramp_sequencer_if.sv | 29 ++
 rtl/pwm_ramp_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_sequencer_if.sv
// Write-only AXI4-Lite link between the ramp sequencer and the PWM core's register port.
interface pwm_ramp_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB,
           M_AXI_WVALID, M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB,
           M_AXI_WVALID, M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Programs the PWM core period, enables it, then ramps the duty register one step per tick.
//
// state       | meaning
// IDLE        | waiting for start
// WR_PERIOD   | writing PERIOD <- cfg_period
// WR_EN       | writing CTRL <- 1
// WR_DUTY     | writing DUTY <- current ramp value
// WAIT_TICK   | C_TICK_DIV cycles between duty writes
// WR_STOP     | writing CTRL <- 0 after abort or error
module pwm_ramp_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_PWM_BASEADDR     = 0,
  parameter int C_CTRL_OFFSET      = 'h0,
  parameter int C_PERIOD_OFFSET    = 'h4,
  parameter int C_DUTY_OFFSET      = 'h8,
  parameter int C_TICK_DIV         = 1000
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  input  logic                          abort,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cfg_period,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cfg_duty_start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cfg_duty_end,
  input  logic [15:0]                   cfg_step,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [C_M_AXI_DATA_WIDTH-1:0] cur_duty,
  pwm_ramp_sequencer_if.master          m_axi
);
  localparam int AW  = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam int DWP = DW + 1;
  localparam int TW  = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LOAD   = TW'(C_TICK_DIV - 1);
  localparam logic [AW-1:0] ADDR_CTRL   = AW'(C_PWM_BASEADDR + C_CTRL_OFFSET);
  localparam logic [AW-1:0] ADDR_PERIOD = AW'(C_PWM_BASEADDR + C_PERIOD_OFFSET);
  localparam logic [AW-1:0] ADDR_DUTY   = AW'(C_PWM_BASEADDR + C_DUTY_OFFSET);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_PERIOD, S_WR_EN, S_WR_DUTY, S_WAIT_TICK, S_WR_STOP
  } state_t;

  state_t          state, state_next;
  logic            awvalid, wvalid, bready, aw_done, w_done;
  logic [AW-1:0]   awaddr, issue_addr;
  logic [DW-1:0]   wdata, issue_data;
  logic [DW-1:0]   duty_q, end_q, duty_next;
  logic [15:0]     step_q;
  logic            dir_up, abort_pend;
  logic [TW-1:0]   tick_cnt;
  logic            issue, aw_hs, w_hs, b_hs, bresp_err, abort_any, accept_start;
  logic [DW:0]     up_sum, dn_floor;

  assign aw_hs        = awvalid && m_axi.M_AXI_AWREADY;
  assign w_hs         = wvalid && m_axi.M_AXI_WREADY;
  assign b_hs         = bready && m_axi.M_AXI_BVALID;
  assign bresp_err    = m_axi.M_AXI_BRESP != 2'b00;
  assign abort_any    = abort || abort_pend;
  assign accept_start = (state == S_IDLE) && start;
  assign busy         = state != S_IDLE;

  assign m_axi.M_AXI_AWADDR  = awaddr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_WDATA   = wdata;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_BREADY  = bready;

  // One bit of headroom so neither direction can wrap past the end value.
  always_comb begin
    up_sum   = {1'b0, duty_q} + DWP'(step_q);
    dn_floor = {1'b0, end_q} + DWP'(step_q);
    if (dir_up)
      duty_next = (up_sum >= {1'b0, end_q}) ? end_q : up_sum[DW-1:0];
    else
      duty_next = ({1'b0, duty_q} <= dn_floor) ? end_q : duty_q - DW'(step_q);
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_addr = '0;
    issue_data = '0;
    case (state)
      S_IDLE: if (start) begin
        state_next = S_WR_PERIOD;
        issue      = 1'b1;
        issue_addr = ADDR_PERIOD;
        issue_data = cfg_period;
      end
      S_WR_PERIOD: if (b_hs) begin
        if (bresp_err || abort_any) state_next = S_WR_STOP;
        else begin
          state_next = S_WR_EN;
          issue      = 1'b1;
          issue_addr = ADDR_CTRL;
          issue_data = DW'(1);
        end
      end
      S_WR_EN: if (b_hs) begin
        if (bresp_err || abort_any) state_next = S_WR_STOP;
        else begin
          state_next = S_WR_DUTY;
          issue      = 1'b1;
          issue_addr = ADDR_DUTY;
          issue_data = duty_q;
        end
      end
      S_WR_DUTY: if (b_hs) begin
        if (bresp_err || abort_any) state_next = S_WR_STOP;
        else if (wdata == end_q)    state_next = S_IDLE;
        else                        state_next = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (abort) state_next = S_WR_STOP;
        else if (tick_cnt == '0) begin
          state_next = S_WR_DUTY;
          issue      = 1'b1;
          issue_addr = ADDR_DUTY;
          issue_data = duty_next;
        end
      end
      S_WR_STOP: if (b_hs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state_next == S_WR_STOP && state != S_WR_STOP) begin
      issue      = 1'b1;
      issue_addr = ADDR_CTRL;
      issue_data = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_IDLE;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      awaddr     <= '0;
      wdata      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cur_duty   <= '0;
      duty_q     <= '0;
      end_q      <= '0;
      step_q     <= '0;
      dir_up     <= 1'b0;
      abort_pend <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      state <= state_next;
      done  <= (state != S_IDLE) && (state_next == S_IDLE);
      if (aw_hs) begin
        awvalid <= 1'b0;
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        wvalid <= 1'b0;
        w_done <= 1'b1;
      end
      if (b_hs) begin
        bready  <= 1'b0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
        bready <= 1'b1;
      end
      if (issue) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        awaddr  <= issue_addr;
        wdata   <= issue_data;
      end
      if (accept_start) begin
        duty_q     <= cfg_duty_start;
        end_q      <= cfg_duty_end;
        step_q     <= (cfg_step == 16'd0) ? 16'd1 : cfg_step;
        dir_up     <= cfg_duty_end >= cfg_duty_start;
        abort_pend <= 1'b0;
        error      <= 1'b0;
      end else if (abort && state != S_IDLE && state != S_WR_STOP) begin
        abort_pend <= 1'b1;
      end
      if (b_hs && bresp_err && state != S_WR_STOP) error <= 1'b1;
      if (b_hs && !bresp_err && state == S_WR_DUTY) cur_duty <= wdata;
      if (state_next == S_WAIT_TICK && state != S_WAIT_TICK) tick_cnt <= TICK_LOAD;
      else if (state == S_WAIT_TICK)                         tick_cnt <= tick_cnt - TW'(1);
      if (state == S_WAIT_TICK && state_next == S_WR_DUTY) duty_q <= duty_next;
    end
  end
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Bench for pwm_ramp_sequencer: AXI4-Lite slave model with adjustable latency and error
// injection, write monitor, and a list-based reference of the expected register writes.
module tb_pwm_ramp_sequencer;
  localparam int TICK_DIV = 4;
  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_PERIOD = 4'h4;
  localparam logic [3:0] A_DUTY   = 4'h8;

  logic        ACLK = 1'b0;
  logic        ARESET, start, abort;
  logic [31:0] cfg_period, cfg_duty_start, cfg_duty_end, cur_duty;
  logic [15:0] cfg_step;
  logic        busy, done, error;

  pwm_ramp_sequencer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi ();

  pwm_ramp_sequencer #(.C_TICK_DIV(TICK_DIV)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .abort(abort),
    .cfg_period(cfg_period), .cfg_duty_start(cfg_duty_start), .cfg_duty_end(cfg_duty_end),
    .cfg_step(cfg_step), .busy(busy), .done(done), .error(error), .cur_duty(cur_duty),
    .m_axi(axi.master)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0, passed = 0, fails = 0;

  // Slave model: READY after a per-run latency, B response once both handshakes are in.
  int aw_lat = 0, w_lat = 0, err_abs = -1;
  int aw_wt, w_wt, s_bidx;
  logic s_aw, s_w;
  always @(posedge ACLK) begin
    if (ARESET) begin
      axi.M_AXI_AWREADY <= 1'b0; axi.M_AXI_WREADY <= 1'b0;
      axi.M_AXI_BVALID <= 1'b0; axi.M_AXI_BRESP <= 2'b00;
      aw_wt <= 0; w_wt <= 0; s_aw <= 1'b0; s_w <= 1'b0; s_bidx <= 0;
    end else begin
      if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
        axi.M_AXI_AWREADY <= (aw_lat == 0); aw_wt <= 0; s_aw <= 1'b1;
      end else if (axi.M_AXI_AWVALID) begin
        if (aw_wt + 1 >= aw_lat) axi.M_AXI_AWREADY <= 1'b1;
        aw_wt <= aw_wt + 1;
      end else axi.M_AXI_AWREADY <= (aw_lat == 0);
      if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
        axi.M_AXI_WREADY <= (w_lat == 0); w_wt <= 0; s_w <= 1'b1;
      end else if (axi.M_AXI_WVALID) begin
        if (w_wt + 1 >= w_lat) axi.M_AXI_WREADY <= 1'b1;
        w_wt <= w_wt + 1;
      end else axi.M_AXI_WREADY <= (w_lat == 0);
      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) axi.M_AXI_BVALID <= 1'b0;
      else if (!axi.M_AXI_BVALID && s_aw && s_w) begin
        axi.M_AXI_BVALID <= 1'b1;
        axi.M_AXI_BRESP  <= (s_bidx == err_abs) ? 2'b10 : 2'b00;
        s_bidx <= s_bidx + 1; s_aw <= 1'b0; s_w <= 1'b0;
      end
    end
  end

  // Monitor: completed writes, duty-to-duty idle gaps, protocol violations.
  logic [35:0] wr_q[$];
  int          gaps[$];
  int          viol = 0, aw_hs = 0, b_hs = 0, cyc = 0, last_b_cyc = 0;
  logic [3:0]  m_addr, last_b_addr;
  logic [31:0] m_data, prev_wdata;
  logic [3:0]  prev_awaddr;
  logic        m_aw, m_w, prev_awv, prev_awpend, prev_wpend;
  always @(posedge ACLK) begin
    if (ARESET) begin
      m_aw <= 1'b0; m_w <= 1'b0; prev_awv <= 1'b0; prev_awpend <= 1'b0; prev_wpend <= 1'b0;
      last_b_addr <= 4'hF;
    end else begin
      cyc <= cyc + 1;
      if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
        m_addr <= axi.M_AXI_AWADDR; m_aw <= 1'b1; aw_hs <= aw_hs + 1;
      end
      if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
        m_data <= axi.M_AXI_WDATA; m_w <= 1'b1;
      end
      viol <= viol
        + int'(m_aw && axi.M_AXI_AWVALID) + int'(m_w && axi.M_AXI_WVALID)
        + int'(prev_wpend && (!axi.M_AXI_WVALID || axi.M_AXI_WDATA !== prev_wdata))
        + int'(prev_awpend && (!axi.M_AXI_AWVALID || axi.M_AXI_AWADDR !== prev_awaddr))
        + int'(axi.M_AXI_BVALID && axi.M_AXI_BREADY && !(m_aw && m_w));
      if (axi.M_AXI_BVALID && axi.M_AXI_BREADY) begin
        wr_q.push_back({m_addr, m_data});
        b_hs <= b_hs + 1; m_aw <= 1'b0; m_w <= 1'b0;
        last_b_addr <= m_addr; last_b_cyc <= cyc;
      end
      if (axi.M_AXI_AWVALID && !prev_awv && last_b_addr == A_DUTY && axi.M_AXI_AWADDR == A_DUTY)
        gaps.push_back(cyc - last_b_cyc - 1);
      prev_awv    <= axi.M_AXI_AWVALID;
      prev_awpend <= axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY;
      prev_wpend  <= axi.M_AXI_WVALID && !axi.M_AXI_WREADY;
      prev_wdata  <= axi.M_AXI_WDATA;
      prev_awaddr <= axi.M_AXI_AWADDR;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the full list of {addr, data} writes for an uninterrupted ramp.
  logic [35:0] exp_q[$];
  logic [31:0] exp_cur = 32'd0;
  task automatic build_full(input logic [31:0] per, ds, de, input logic [15:0] st);
    longint d, e, s;
    exp_q.delete();
    exp_q.push_back({A_PERIOD, per});
    exp_q.push_back({A_CTRL, 32'd1});
    d = longint'(ds); e = longint'(de); s = (st == 16'd0) ? 1 : longint'(st);
    for (int n = 0; n < 100000; n++) begin
      exp_q.push_back({A_DUTY, d[31:0]});
      if (d == e) break;
      if (de >= ds) d = (d + s > e) ? e : d + s;
      else          d = (d - s < e) ? e : d - s;
    end
  endtask

  // abort_n >= 0: abort in the tick wait after that many writes; -2: abort together with start.
  task automatic run(input string name, input logic [31:0] per, ds, de, input logic [15:0] st,
                     input int err_k, input int abort_n, input bit ign);
    int  wb, gb, ab, bb, vb, done_cnt, exp_gaps;
    bit  fin, ab_sent, ig_sent, e_err;
    build_full(per, ds, de, st);
    e_err = (err_k >= 0 && err_k < exp_q.size());
    if (e_err) begin
      while (exp_q.size() > err_k + 1) void'(exp_q.pop_back());
      exp_q.push_back({A_CTRL, 32'd0});
    end else if (abort_n >= 0 && abort_n < exp_q.size()) begin
      while (exp_q.size() > abort_n) void'(exp_q.pop_back());
      exp_q.push_back({A_CTRL, 32'd0});
    end
    exp_gaps = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i][35:32] == A_DUTY && !(e_err && i == err_k)) exp_cur = exp_q[i][31:0];
      if (i + 1 < exp_q.size() && exp_q[i][35:32] == A_DUTY && exp_q[i+1][35:32] == A_DUTY)
        exp_gaps++;
    end
    wb = wr_q.size(); gb = gaps.size(); ab = aw_hs; bb = b_hs; vb = viol;
    err_abs = e_err ? s_bidx + err_k : -1;
    cfg_period = per; cfg_duty_start = ds; cfg_duty_end = de; cfg_step = st;
    start = 1'b1; abort = (abort_n == -2);
    @(posedge ACLK); #1;
    start = 1'b0; abort = 1'b0;
    check({name, " busy_after_start"}, busy, 1);
    check({name, " awvalid_after_start"}, axi.M_AXI_AWVALID, 1);
    check({name, " wvalid_after_start"}, axi.M_AXI_WVALID, 1);
    check({name, " error_cleared"}, error, 0);
    fin = 0; ab_sent = 0; ig_sent = 0; done_cnt = 0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge ACLK); #1;
      start = 1'b0; abort = 1'b0;
      if (done) done_cnt++;
      if (!busy) begin fin = 1; break; end
      if (abort_n >= 0 && !ab_sent && wr_q.size() - wb == abort_n && !axi.M_AXI_AWVALID) begin
        abort = 1'b1; ab_sent = 1;
      end
      if (ign && !ig_sent && wr_q.size() - wb == 3) begin
        start = 1'b1; cfg_period = $urandom; cfg_duty_start = $urandom;
        cfg_duty_end = $urandom; cfg_step = 16'($urandom); ig_sent = 1;
      end
    end
    check({name, " finished_in_budget"}, fin, 1);
    if (!fin) begin
      ARESET = 1'b1; @(posedge ACLK); #1; ARESET = 1'b0; exp_cur = 32'd0;
    end
    repeat (2) begin
      @(posedge ACLK); #1;
      if (done) done_cnt++;
    end
    check({name, " done_pulses"}, done_cnt, 1);
    check({name, " error"}, error, e_err);
    check({name, " cur_duty"}, cur_duty, exp_cur);
    check({name, " write_count"}, wr_q.size() - wb, exp_q.size());
    check({name, " one_b_per_aw"}, aw_hs - ab, b_hs - bb);
    check({name, " protocol_viol"}, viol - vb, 0);
    for (int i = 0; i < exp_q.size() && wb + i < wr_q.size(); i++)
      check($sformatf("%s wr%0d", name, i), wr_q[wb + i], exp_q[i]);
    check({name, " gap_count"}, gaps.size() - gb, exp_gaps);
    for (int i = gb; i < gaps.size(); i++)
      check($sformatf("%s gap%0d", name, i - gb), gaps[i], TICK_DIV);
  endtask

  initial begin
    ARESET = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_period = '0; cfg_duty_start = '0; cfg_duty_end = '0; cfg_step = '0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst cur_duty", cur_duty, 0);
    check("rst awvalid", axi.M_AXI_AWVALID, 0);
    check("rst wvalid", axi.M_AXI_WVALID, 0);
    check("rst bready", axi.M_AXI_BREADY, 0);
    check("rst awaddr", axi.M_AXI_AWADDR, 0);
    check("rst wdata", axi.M_AXI_WDATA, 0);
    check("awprot", axi.M_AXI_AWPROT, 0);
    check("wstrb", axi.M_AXI_WSTRB, 4'hF);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    run("up",      32'd100, 32'd10, 32'd40, 16'd10, -1, -1, 0);
    run("down",    32'd100, 32'd40, 32'd5,  16'd20, -1, -1, 0);
    run("step0",   32'd50,  32'd0,  32'd3,  16'd0,  -1, -1, 0);
    run("equal",   32'd50,  32'd7,  32'd7,  16'd3,  -1, -1, 0);
    run("slverr",  32'd100, 32'd10, 32'd40, 16'd10,  0, -1, 0);
    run("abort",   32'd100, 32'd10, 32'd40, 16'd10, -1,  4, 0);
    run("st_ab",   32'd100, 32'd10, 32'd30, 16'd10, -1, -2, 0);
    run("top",     32'd9,   32'hFFFF_FF00, 32'hFFFF_FFFF, 16'h0080, -1, -1, 0);
    run("floor",   32'd9,   32'd100, 32'd0, 16'd60, -1, -1, 0);
    aw_lat = 3; w_lat = 0;
    run("bp",      32'd100, 32'd10, 32'd40, 16'd10, -1, -1, 1);
    run("bp_err",  32'd100, 32'd10, 32'd40, 16'd10,  3, -1, 0);

    for (int r = 0; r < 10; r++) begin
      logic [31:0] per, ds, de;
      logic [15:0] st;
      int ek;
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
      per = $urandom; ds = $urandom_range(0, 100); de = $urandom_range(0, 100);
      st = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      build_full(per, ds, de, st);
      ek = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
      run($sformatf("rnd%0d", r), per, ds, de, st, ek, -1, 0);
    end

    // Reset while a write is still waiting for AWREADY.
    aw_lat = 3; w_lat = 3;
    cfg_period = 32'd77; cfg_duty_start = 32'd1; cfg_duty_end = 32'd2; cfg_step = 16'd1;
    start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    check("midrst awvalid_before", axi.M_AXI_AWVALID, 1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    check("midrst awvalid", axi.M_AXI_AWVALID, 0);
    check("midrst wvalid", axi.M_AXI_WVALID, 0);
    check("midrst bready", axi.M_AXI_BREADY, 0);
    check("midrst busy", busy, 0);
    check("midrst cur_duty", cur_duty, 0);
    ARESET = 1'b0; exp_cur = 32'd0;
    @(posedge ACLK); #1;
    aw_lat = 0; w_lat = 0;
    run("after_rst", 32'd20, 32'd6, 32'd0, 16'd4, -1, -1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
